nvram_hps_bridge: RTL

Moves the 256-byte high-score NVRAM shadow array between the X2212 emulation and the MiSTer HPS ioctl channel. It loads the save file from SD into the shadow array at boot and then requests a recall so the game sees it. It also serves the shadow array back to the HPS on upload (save). It sits beside the NVRAM core on the shadow array's second port, between the core and the HPS interface in the top level.

---
 rtl/nvram_pkg.sv | 19 +
 rtl/nvram_hps_bridge.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nvram_pkg.sv
// Shared constants and FSM state type for the high-score NVRAM bridge.
// Used by nvram_hps_bridge; see that file for the NVRAM_AUTOSAVE_EN option.
package nvram_pkg;

    localparam int         NV_DEPTH         = 256;
    localparam int         NV_ADDR_W        = 8;
    localparam logic [7:0] NV_INDEX_DEFAULT = 8'd4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DL_HOLD  = 3'd1,
        DL_WRITE = 3'd2,
        UL_ADDR  = 3'd3,
        UL_DATA  = 3'd4,
        UL_OUT   = 3'd5,
        RECALL   = 3'd6
    } nv_bridge_state_t;

endpackage

// File: rtl/nvram_hps_bridge.sv
// Moves the NVRAM shadow array between the HPS ioctl channel and the X2212 core.
// Define NVRAM_AUTOSAVE_EN to add the dirty output for OSD autosave.
module nvram_hps_bridge
    import nvram_pkg::*;
#(
    parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT,
    parameter int         DEPTH    = NV_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_upload,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic                 ioctl_rd,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [7:0]           ioctl_din,
    output logic                 ioctl_wait,
    input  logic                 store_busy,
    input  logic                 store_pulse,
    output logic                 sh_sel,
    output logic [NV_ADDR_W-1:0] sh_addr,
    output logic                 sh_we,
    output logic [7:0]           sh_din,
    input  logic [7:0]           sh_dout,
    output logic                 recall_req,
`ifdef NVRAM_AUTOSAVE_EN
    output logic                 dirty,
`endif
    output logic                 loaded
);

    nv_bridge_state_t state;

    logic                 nv_sel;
    logic                 addr_ok;
    logic                 wr_hit;
    logic                 rd_hit;
    logic [NV_ADDR_W-1:0] buf_addr;
    logic [7:0]           buf_data;
    logic [NV_ADDR_W-1:0] ul_addr;
    logic                 ul_oor;
    logic                 got_byte;
    logic                 rec_pend;
    logic                 dl_q1;
    logic                 dl_q2;
    logic                 dl_fall;

    assign nv_sel  = (ioctl_index == NV_INDEX);
    assign addr_ok = (ioctl_addr < 25'(DEPTH));
    assign wr_hit  = nv_sel & ioctl_download & ioctl_wr & addr_ok;
    // A write strobe always shadows a read strobe in the same cycle.
    assign rd_hit  = nv_sel & ioctl_upload & ioctl_rd & ~ioctl_wr;
    assign dl_fall = dl_q2 & ~dl_q1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ioctl_wait <= 1'b0;
            ioctl_din  <= 8'h00;
            buf_addr   <= '0;
            buf_data   <= 8'h00;
            ul_addr    <= '0;
            ul_oor     <= 1'b0;
            got_byte   <= 1'b0;
            rec_pend   <= 1'b0;
            loaded     <= 1'b0;
            dl_q1      <= 1'b0;
            dl_q2      <= 1'b0;
        end else begin
            dl_q1 <= ioctl_download & nv_sel;
            dl_q2 <= dl_q1;
            // Remember an end-of-download seen while busy elsewhere.
            if (dl_fall) rec_pend <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (wr_hit) begin
                        buf_addr <= ioctl_addr[NV_ADDR_W-1:0];
                        buf_data <= ioctl_dout;
                        if (store_busy) begin
                            ioctl_wait <= 1'b1;
                            state      <= DL_HOLD;
                        end else begin
                            state <= DL_WRITE;
                        end
                    end else if (rd_hit) begin
                        ul_addr    <= ioctl_addr[NV_ADDR_W-1:0];
                        ul_oor     <= ~addr_ok;
                        ioctl_wait <= 1'b1;
                        state      <= UL_ADDR;
                    end else if (dl_fall | rec_pend) begin
                        rec_pend <= 1'b0;
                        if (got_byte) state <= RECALL;
                    end
                end
                DL_HOLD: begin
                    if (!store_busy) state <= DL_WRITE;
                end
                DL_WRITE: begin
                    got_byte   <= 1'b1;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                UL_ADDR: begin
                    state <= UL_DATA;
                end
                UL_DATA: begin
                    ioctl_din <= ul_oor ? 8'h00 : sh_dout;
                    state     <= UL_OUT;
                end
                UL_OUT: begin
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                RECALL: begin
                    loaded   <= 1'b1;
                    got_byte <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sh_sel     = (state == DL_WRITE) | (state == UL_ADDR)
                      | (state == UL_DATA);
    assign sh_we      = (state == DL_WRITE);
    assign sh_addr    = sh_we ? buf_addr : (sh_sel ? ul_addr : '0);
    assign sh_din     = sh_we ? buf_data : 8'h00;
    assign recall_req = (state == RECALL);

`ifdef NVRAM_AUTOSAVE_EN
    logic ul_q;
    logic ul_fall;

    assign ul_fall = ul_q & ~(ioctl_upload & nv_sel);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ul_q  <= 1'b0;
            dirty <= 1'b0;
        end else begin
            ul_q <= ioctl_upload & nv_sel;
            // A fresh store outranks a save finishing in the same cycle.
            if (store_pulse)  dirty <= 1'b1;
            else if (ul_fall) dirty <= 1'b0;
        end
    end
`else
    logic unused_store;
    assign unused_store = store_pulse;
`endif

endmodule
